// File: rtl/reg_wrt_sched.sv
// Write-port scheduler for the 8x8 register file: after reset it loads reg i = i,
// then round-robins the single write port between ALU and load writeback.
module reg_wrt_sched #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter bit          INIT_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_req,
  input  logic [ADDR_W-1:0] alu_dst,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_gnt,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_gnt,
  output logic              reg_wrt,
  output logic [ADDR_W-1:0] reg_wrt_dst,
  output logic [DATA_W-1:0] wrt_data,
  output logic              init_done
);

  typedef enum logic { S_INIT, S_RUN } state_t;
  typedef enum logic { P_ALU, P_MEM } prio_t;

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(NUM_REGS - 1);

  state_t            state_q;
  prio_t             prio_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] init_data;
  logic              run;

  always_comb begin
    run       = (state_q == S_RUN);
    init_data = DATA_W'(cnt_q[ADDR_W-1:0]);
    // Gated by rst so grants also drop during reset in a build without init.
    alu_gnt   = rst & run & alu_req & (~mem_req | (prio_q == P_ALU));
    mem_gnt   = rst & run & mem_req & (~alu_req | (prio_q == P_MEM));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT_EN ? S_INIT : S_RUN;
      prio_q      <= P_ALU;
      cnt_q       <= '0;
      reg_wrt     <= 1'b0;
      reg_wrt_dst <= '0;
      wrt_data    <= '0;
      init_done   <= ~INIT_EN;
    end else begin
      case (state_q)
        S_INIT: begin
          reg_wrt     <= 1'b1;
          reg_wrt_dst <= cnt_q[ADDR_W-1:0];
          wrt_data    <= init_data;
          cnt_q       <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q   <= S_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          if (alu_gnt) begin
            reg_wrt     <= 1'b1;
            reg_wrt_dst <= alu_dst;
            wrt_data    <= alu_data;
          end else if (mem_gnt) begin
            reg_wrt     <= 1'b1;
            reg_wrt_dst <= mem_dst;
            wrt_data    <= mem_data;
          end else begin
            reg_wrt <= 1'b0;
          end
          // Only a contested cycle hands priority to the requester just passed over.
          if (alu_req && mem_req) begin
            prio_q <= (prio_q == P_ALU) ? P_MEM : P_ALU;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_wrt_sched.sv
// Randomised bench for reg_wrt_sched against a cycle-level reference model,
// plus directed checks for async reset and an INIT_EN=0 build.
module tb_reg_wrt_sched;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_req, m_req;
  logic [2:0] a_dst, m_dst;
  logic [7:0] a_dat, m_dat;
  logic       alu_gnt, mem_gnt, reg_wrt, init_done;
  logic [2:0] reg_wrt_dst;
  logic [7:0] wrt_data;

  logic       z_rst, z_areq, z_mreq;
  logic [2:0] z_adst, z_mdst;
  logic [7:0] z_adat, z_mdat;
  logic       z_agnt, z_mgnt, z_wrt, z_done;
  logic [2:0] z_wdst;
  logic [7:0] z_wdat;

  reg_wrt_sched #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8), .INIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alu_req(a_req), .alu_dst(a_dst), .alu_data(a_dat), .alu_gnt(alu_gnt),
    .mem_req(m_req), .mem_dst(m_dst), .mem_data(m_dat), .mem_gnt(mem_gnt),
    .reg_wrt(reg_wrt), .reg_wrt_dst(reg_wrt_dst), .wrt_data(wrt_data),
    .init_done(init_done)
  );

  reg_wrt_sched #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8), .INIT_EN(1'b0)) dut0 (
    .clk(clk), .rst(z_rst),
    .alu_req(z_areq), .alu_dst(z_adst), .alu_data(z_adat), .alu_gnt(z_agnt),
    .mem_req(z_mreq), .mem_dst(z_mdst), .mem_data(z_mdat), .mem_gnt(z_mgnt),
    .reg_wrt(z_wrt), .reg_wrt_dst(z_wdst), .wrt_data(z_wdat),
    .init_done(z_done)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: init progress, whose turn it is, expected write port.
  bit m_run, m_prio_mem, e_wrt, e_done, e_ag, e_mg;
  int m_idx, e_dst, e_dat, a_wait, m_wait;

  task automatic model_reset();
    m_run = 1'b0; m_idx = 0; m_prio_mem = 1'b0;
    e_wrt = 1'b0; e_dst = 0; e_dat = 0; e_done = 1'b0;
    e_ag = 1'b0; e_mg = 1'b0; a_wait = 0; m_wait = 0;
  endtask

  task automatic step();
    bit run_pre;
    @(negedge clk);
    run_pre = m_run;
    e_ag = m_run && a_req && (!m_req || !m_prio_mem);
    e_mg = m_run && m_req && (!a_req || m_prio_mem);
    check_eq("alu_gnt", 32'(alu_gnt), 32'(e_ag));
    check_eq("mem_gnt", 32'(mem_gnt), 32'(e_mg));
    if (run_pre && a_req) check_eq("alu_wait_le1", 32'(a_wait <= 1), 32'd1);
    if (run_pre && m_req) check_eq("mem_wait_le1", 32'(m_wait <= 1), 32'd1);
    a_wait = (run_pre && a_req && !alu_gnt) ? a_wait + 1 : 0;
    m_wait = (run_pre && m_req && !mem_gnt) ? m_wait + 1 : 0;
    if (!m_run) begin
      e_wrt = 1'b1; e_dst = m_idx; e_dat = m_idx;
      m_idx++;
      if (m_idx == 8) begin m_run = 1'b1; e_done = 1'b1; end
    end else begin
      if (e_ag)      begin e_wrt = 1'b1; e_dst = a_dst; e_dat = a_dat; end
      else if (e_mg) begin e_wrt = 1'b1; e_dst = m_dst; e_dat = m_dat; end
      else           e_wrt = 1'b0;
      if (a_req && m_req) m_prio_mem = !m_prio_mem;
    end
    @(posedge clk);
    #1;
    check_eq("reg_wrt",     32'(reg_wrt),     32'(e_wrt));
    check_eq("reg_wrt_dst", 32'(reg_wrt_dst), 32'(e_dst));
    check_eq("wrt_data",    32'(wrt_data),    32'(e_dat));
    check_eq("init_done",   32'(init_done),   32'(e_done));
  endtask

  task automatic next_reqs();
    if (!a_req || e_ag) begin
      a_req = ($urandom_range(0, 3) != 0);
      a_dst = 3'($urandom); a_dat = 8'($urandom);
    end
    if (!m_req || e_mg) begin
      m_req = ($urandom_range(0, 3) != 0);
      m_dst = 3'($urandom); m_dat = 8'($urandom);
    end
  endtask

  initial begin
    rst = 1'b0; a_req = 1'b0; m_req = 1'b0;
    a_dst = '0; a_dat = '0; m_dst = '0; m_dat = '0;
    z_rst = 1'b0; z_areq = 1'b0; z_mreq = 1'b0;
    z_adst = '0; z_adat = '0; z_mdst = '0; z_mdat = '0;
    model_reset();

    #1;
    check_eq("rst_reg_wrt",   32'(reg_wrt),     32'd0);
    check_eq("rst_dst",       32'(reg_wrt_dst), 32'd0);
    check_eq("rst_data",      32'(wrt_data),    32'd0);
    check_eq("rst_init_done", 32'(init_done),   32'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (9) step();

    repeat (150) begin step(); next_reqs(); end

    // Async reset while a write is on the port, with an ALU request held through init.
    a_req = 1'b1; a_dst = 3'd6; a_dat = 8'h3C; m_req = 1'b0;
    step();
    check_eq("pre_rst_wrt", 32'(reg_wrt), 32'd1);
    #3;
    rst = 1'b0;
    a_req = 1'b1; a_dst = 3'd5; a_dat = 8'hA5;
    #1;
    check_eq("arst_reg_wrt",   32'(reg_wrt),     32'd0);
    check_eq("arst_init_done", 32'(init_done),   32'd0);
    check_eq("arst_alu_gnt",   32'(alu_gnt),     32'd0);
    check_eq("arst_mem_gnt",   32'(mem_gnt),     32'd0);
    check_eq("arst_dst",       32'(reg_wrt_dst), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    repeat (9) step();
    check_eq("held_alu_wrt", 32'({reg_wrt, reg_wrt_dst, wrt_data}), 32'({1'b1, 3'd5, 8'hA5}));
    a_req = 1'b0;

    a_req = 1'b1; a_dst = 3'd2; a_dat = 8'h11;
    m_req = 1'b1; m_dst = 3'd3; m_dat = 8'h22;
    repeat (6) step();
    a_req = 1'b0;
    m_dst = 3'd4; m_dat = 8'h7E;
    repeat (3) step();
    a_req = 1'b1; a_dst = 3'd2; a_dat = 8'h11;
    step();
    check_eq("contest_after_mem_only", 32'(reg_wrt_dst), 32'd2);
    step();
    a_req = 1'b0; m_req = 1'b0;
    step();

    repeat (150) begin step(); next_reqs(); end

    // INIT_EN=0 build: ready straight out of reset, first grant right after release.
    z_areq = 1'b1; z_adst = 3'd1; z_adat = 8'hFF;
    #1;
    check_eq("z_rst_done", 32'(z_done), 32'd1);
    check_eq("z_rst_wrt",  32'(z_wrt),  32'd0);
    check_eq("z_rst_gnt",  32'(z_agnt), 32'd0);
    @(posedge clk);
    #1 z_rst = 1'b1;
    #1;
    check_eq("z_alu_gnt", 32'(z_agnt), 32'd1);
    check_eq("z_mem_gnt", 32'(z_mgnt), 32'd0);
    @(posedge clk);
    #1;
    check_eq("z_wrt",  32'(z_wrt),  32'd1);
    check_eq("z_dst",  32'(z_wdst), 32'd1);
    check_eq("z_data", 32'(z_wdat), 32'hFF);
    check_eq("z_done", 32'(z_done), 32'd1);
    z_areq = 1'b0;
    @(posedge clk);
    #1;
    check_eq("z_idle_wrt", 32'(z_wrt),  32'd0);
    check_eq("z_idle_dst", 32'(z_wdst), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
